// File: rtl/onehot_encoder.sv
// Registered one-hot to binary encoder: a two-stage valid/ready pipeline that turns one-hot
// select/grant vectors back into indices and counts vectors that were not one-hot.
module onehot_encoder #(
  parameter int N     = 32,
  parameter int OUT_W = 5,
  parameter int GROUP = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     A,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] Z,
  output logic             err_zero,
  output logic             err_multi,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
);

  localparam int NG  = N / GROUP;
  localparam int GW  = $clog2(GROUP);
  localparam int GIW = OUT_W - GW;

  logic s1Adv;
  logic s2Adv;
  logic s2Load;

  logic            s1Valid_q;
  logic [NG-1:0]   s1Any_q;
  logic [NG-1:0]   s1Multi_q;
  logic [GW-1:0]   s1Idx_q [NG];

  logic [NG-1:0]   grpAny_d;
  logic [NG-1:0]   grpMulti_d;
  logic [GW-1:0]   grpIdx_d [NG];

  logic             outValid_q;
  logic [OUT_W-1:0] z_q;
  logic             errZero_q;
  logic             errMulti_q;
  logic [CNT_W-1:0] errCount_q;

  logic [OUT_W-1:0] z_d;
  logic             errZero_d;
  logic             errMulti_d;
  logic [GIW-1:0]   grpSel;
  logic             grpFound;
  logic             grpTwo;

  assign s2Adv    = !outValid_q || out_ready;
  assign s1Adv    = !s1Valid_q || s2Adv;
  assign in_ready = s1Adv;
  assign s2Load   = s2Adv && s1Valid_q;

  // Per-group summary: scanning from the top down leaves the lowest set bit in grpIdx_d.
  always_comb begin
    for (int g = 0; g < NG; g++) begin
      grpAny_d[g]   = 1'b0;
      grpMulti_d[g] = 1'b0;
      grpIdx_d[g]   = '0;
      for (int b = GROUP - 1; b >= 0; b--) begin
        if (A[g*GROUP + b]) begin
          if (grpAny_d[g]) begin
            grpMulti_d[g] = 1'b1;
          end
          grpAny_d[g] = 1'b1;
          grpIdx_d[g] = GW'(b);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Any_q   <= '0;
      s1Multi_q <= '0;
      for (int g = 0; g < NG; g++) begin
        s1Idx_q[g] <= '0;
      end
    end else if (s1Adv) begin
      s1Valid_q <= in_valid;
      if (in_valid) begin
        s1Any_q   <= grpAny_d;
        s1Multi_q <= grpMulti_d;
        for (int g = 0; g < NG; g++) begin
          s1Idx_q[g] <= grpIdx_d[g];
        end
      end
    end
  end

  // Lowest active group wins; a second active group or any in-group collision marks multi-hot.
  always_comb begin
    grpSel   = '0;
    grpFound = 1'b0;
    grpTwo   = 1'b0;
    for (int g = 0; g < NG; g++) begin
      if (s1Any_q[g]) begin
        if (grpFound) begin
          grpTwo = 1'b1;
        end else begin
          grpFound = 1'b1;
          grpSel   = GIW'(g);
        end
      end
    end
    errZero_d  = !grpFound;
    errMulti_d = grpTwo || (|s1Multi_q);
    z_d        = grpFound ? {grpSel, s1Idx_q[grpSel]} : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      z_q        <= '0;
      errZero_q  <= 1'b0;
      errMulti_q <= 1'b0;
    end else if (s2Adv) begin
      outValid_q <= s1Valid_q;
      if (s1Valid_q) begin
        z_q        <= z_d;
        errZero_q  <= errZero_d;
        errMulti_q <= errMulti_d;
      end
    end
  end

  // A clear request overrides a simultaneous increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errCount_q <= '0;
    end else if (err_clr) begin
      errCount_q <= '0;
    end else if (s2Load && (errZero_d || errMulti_d) && (errCount_q != '1)) begin
      errCount_q <= errCount_q + 1'b1;
    end
  end

  assign out_valid = outValid_q;
  assign Z         = z_q;
  assign err_zero  = errZero_q;
  assign err_multi = errMulti_q;
  assign err_count = errCount_q;

endmodule

// File: tb/tb_onehot_encoder.sv
// Scoreboard bench for onehot_encoder: expected results are queued at input acceptance
// and compared when the encoder hands a result downstream.
module tb_onehot_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  Z;
  logic        err_zero;
  logic        err_multi;
  logic [7:0]  err_count;
  logic        err_clr;

  typedef struct {
    logic [4:0] z;
    logic       zero;
    logic       multi;
    int         cyc;
  } exp_t;

  exp_t sbQ[$];
  exp_t monE;
  int   testsRun;
  int   testsFailed;
  int   cycleCnt;
  bit   checkLat;

  onehot_encoder #(.N(32), .OUT_W(5), .GROUP(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z),
    .err_zero  (err_zero),
    .err_multi (err_multi),
    .err_count (err_count),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycleCnt = 0;
  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result from a plain scan of the whole vector, independent of any grouping.
  function automatic exp_t modelOf(input logic [31:0] v, input int cyc);
    exp_t e;
    e.z     = '0;
    e.zero  = (v == 32'h0);
    e.multi = ($countones(v) > 1);
    e.cyc   = cyc;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) e.z = 5'(i);
    end
    return e;
  endfunction

  // Transfers are decided by values that are already stable at the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedOut", {31'b0, out_valid}, 32'h0);
        end else begin
          monE = sbQ.pop_front();
          checkOutput("Z", {27'b0, Z}, {27'b0, monE.z});
          checkOutput("errZero", {31'b0, err_zero}, {31'b0, monE.zero});
          checkOutput("errMulti", {31'b0, err_multi}, {31'b0, monE.multi});
          if (checkLat) checkOutput("latency", cycleCnt - monE.cyc, 32'd2);
        end
      end
      if (in_valid && in_ready) sbQ.push_back(modelOf(A, cycleCnt));
    end
  end

  task automatic applyStimulus(input logic [31:0] vec);
    bit acc;
    int waitCnt;
    A        = vec;
    in_valid = 1'b1;
    acc      = 1'b0;
    waitCnt  = 0;
    while (!acc && waitCnt < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waitCnt++;
    end
    if (!acc) checkOutput("acceptTimeout", {31'b0, acc}, 32'h1);
  endtask

  task automatic idleInput();
    in_valid = 1'b0;
    A        = $urandom;
  endtask

  task automatic drainWait();
    int waitCnt;
    waitCnt = 0;
    while (sbQ.size() != 0 && waitCnt < 50) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("drain", sbQ.size(), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    checkLat    = 1'b0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    A           = '0;
    out_ready   = 1'b1;
    err_clr     = 1'b0;

    #1;
    checkOutput("rstOutValid", {31'b0, out_valid}, 32'h0);
    checkOutput("rstZ", {27'b0, Z}, 32'h0);
    checkOutput("rstErrZero", {31'b0, err_zero}, 32'h0);
    checkOutput("rstErrMulti", {31'b0, err_multi}, 32'h0);
    checkOutput("rstErrCount", {24'b0, err_count}, 32'h0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 checkOutput("rstInReady", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;

    // Walking one across every position, back to back.
    checkLat = 1'b1;
    for (int i = 0; i < 32; i++) applyStimulus(32'h1 << i);
    idleInput();
    drainWait();
    checkLat = 1'b0;
    checkOutput("sweepErrCount", {24'b0, err_count}, 32'd0);

    applyStimulus(32'h0);
    idleInput();
    drainWait();
    checkOutput("zeroErrCount", {24'b0, err_count}, 32'd1);

    applyStimulus(32'h0000_0110);
    applyStimulus(32'h8001_0000);
    idleInput();
    drainWait();
    checkOutput("multiErrCount", {24'b0, err_count}, 32'd3);

    // Downstream stalls with three vectors offered.
    out_ready = 1'b0;
    applyStimulus(32'h1 << 3);
    applyStimulus(32'h1 << 9);
    A        = 32'h1 << 27;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bpInReady", {31'b0, in_ready}, 32'h0);
      checkOutput("bpOutValid", {31'b0, out_valid}, 32'h1);
      checkOutput("bpZHeld", {27'b0, Z}, 32'd3);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    applyStimulus(32'h1 << 27);
    idleInput();
    drainWait();

    for (int i = 0; i < 260; i++) applyStimulus(32'h0);
    idleInput();
    drainWait();
    checkOutput("satErrCount", {24'b0, err_count}, 32'd255);
    applyStimulus(32'h0);
    idleInput();
    drainWait();
    checkOutput("satHold", {24'b0, err_count}, 32'd255);

    // Clear lands on the same edge the error vector enters stage 2.
    applyStimulus(32'h0);
    idleInput();
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    drainWait();
    checkOutput("clrErrCount", {24'b0, err_count}, 32'd0);

    applyStimulus(32'h1 << 5);
    applyStimulus(32'h1 << 6);
    idleInput();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstOutValid", {31'b0, out_valid}, 32'h0);
    checkOutput("midRstZ", {27'b0, Z}, 32'h0);
    sbQ.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("noStaleOut", {31'b0, out_valid}, 32'h0);
    end

    applyStimulus(32'h8000_0000);
    idleInput();
    drainWait();
    checkOutput("finalErrCount", {24'b0, err_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
